inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction fetch stage front end. Owns the PC and issues one-at-a-time requests to the instruction memory over an addr_ok/data_ok handshake. Buffers returned instructions, with their PC and branch-prediction metadata, in a 2-entry queue. Presents the queue head to the IF/ID pipeline register as if_pc/if_inst/if_valid.

## Interface
- RESET_PC, 32'hBFC0_0000, first fetch address after reset.
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- stall  in  stall_t  only stall_if is used; 1 = IF/ID does not sample this cycle.
- flush  in  1  exception/eret redirect to flush_pc.
- flush_pc  in  32  redirect target for flush.
- branch_flag  in  1  decode-stage redirect (mispredict) to branch_target.
- branch_target  in  32  redirect target for branch_flag.
- bp_taken, bp_state[1:0], bp_target[31:0]  in  predictor lookup for the current PC (combinational, external).
- imem_req  out  1  request valid.
- imem_addr  out  32  request address.
- imem_addr_ok  in  1  request accepted this cycle.
- imem_data_ok  in  1  response valid.
- imem_rdata  in  32  response data.
- pc_ce  out  1  0 in the first cycle after reset release, 1 thereafter.
- if_pc, if_inst  out  32  queue-head PC and instruction.
- if_valid  out  1  queue head valid.
- if_except  out  exceptType_t  only the instruction-address-error field is driven; other fields are 0.
- if_branch_predict, if_branch_predict_state[1:0], if_branch_predict_target[31:0]  out  queue-head prediction metadata.

## Operation
- Reset values:
  - pc = RESET_PC; pc_ce = 0.
  - Queue empty; if_valid = 0; all if_* data outputs = 0.
  - imem_req = 0; cancel = 0; halted = 0.
- Issue rule:
  - imem_req = 1 when not halted, pc[1:0] == 0, no response is outstanding, and (queue entries − pop this cycle) < 2.
  - Once raised, imem_req and imem_addr hold unchanged until imem_addr_ok, even across redirects.
- Acceptance (req && addr_ok):
  - pc, bp_taken, bp_state and bp_target are latched as the in-flight tag.
  - pc advances to bp_taken ? bp_target : pc+4.
  - outstanding = 1.
- Response (data_ok with outstanding):
  - If cancel = 1: drop the data; clear cancel and outstanding.
  - Otherwise: push {tag, rdata} into the queue and clear outstanding.
  - A new request may be raised in the same cycle, subject to the issue rule.
- Pop: queue head is consumed on any cycle where if_valid && !stall_if.
- Misaligned PC (pc[1:0] != 0, not halted, slot free):
  - No memory request is made.
  - Push an entry with inst = 0, address-error = 1, prediction fields = 0.
  - Set halted = 1. Fetching stops until flush.
- Redirect priority: flush > branch_flag. On redirect:
  - Queue cleared the same edge; a pop in that cycle is ignored.
  - pc = target; halted = 0.
  - An outstanding or accepted-this-cycle request sets cancel = 1.
  - A request raised but not yet accepted stays raised; it is cancelled once accepted.
  - The new pc is requested only after that request completes.
- Reset asserted mid-transfer: all state returns to reset values immediately. Any later data_ok is ignored (outstanding = 0).
- Widths: pc+4 wraps modulo 2^32.

## Timing
- Zero-wait memory (addr_ok in the request cycle, data_ok in the next cycle):
  - Cycle 0 after reset release: req at RESET_PC; pc_ce = 0.
  - Cycle 1: data_ok; pc_ce = 1.
  - Cycle 2: if_valid = 1.
- Sustained throughput is one instruction per 2 cycles, because only one request is outstanding.
- if_* outputs are registered from the queue head and stay stable while stall_if = 1.
- Redirect:
  - if_valid = 0 on the next cycle.
  - The first instruction from the target appears ≥2 cycles after the cancelled response completes.
- Queue full (2 entries) with stall_if held: imem_req = 0; no data is lost. Queue capacity covers the one in-flight response.

## Test plan
- Reset release, zero-wait memory returning imem_rdata = addr ^ 32'h1111_1111 -> if_pc sequence BFC00000, BFC00004, BFC00008 with matching if_inst; pc_ce 0 then 1.
- stall_if held 6 cycles mid-stream -> queue fills to 2, then imem_req = 0; if_pc/if_inst are constant during the stall; no instruction is skipped or duplicated after release.
- bp_taken = 1 with bp_target = 8000_0100 at pc 8000_0010 -> next if_pc = 8000_0100; the entry for 8000_0010 carries if_branch_predict = 1, state and target as supplied.
- branch_flag with branch_target = 8000_0200 while a request is outstanding and data_ok is delayed 3 cycles -> stale data dropped; queue empty next cycle; next if_pc = 8000_0200.
- flush to 8000_0380 asserted in the same cycle as branch_flag -> flush wins; if_pc = 8000_0380.
- branch_target = 8000_0002 -> no imem_req; one entry with address-error = 1, if_inst = 0; fetching halts until flush to BFC00380 resumes it.

Source files
------------

// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch -- instruction fetch front end.
//
// Owns the PC. Issues one request at a time to the instruction memory over an
// addr_ok/data_ok handshake. Buffers each returned instruction, with its PC
// and branch-prediction metadata, in a 2-entry queue whose head drives the
// IF/ID register inputs.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   stall                      pipeline stall vector (only stall_if used)
//   flush, flush_pc            exception/eret redirect (highest priority)
//   branch_flag, branch_target decode-stage mispredict redirect
//   bp_taken/state/target      predictor lookup for the current PC
//   imem_req/addr              request valid / address (held until addr_ok)
//   imem_addr_ok               request accepted this cycle
//   imem_data_ok/rdata         response valid / data
//   pc_ce                      0 in the first cycle after reset, then 1
//   if_pc/inst/valid           queue head
//   if_except                  queue head exception (address error only)
//   if_branch_predict*         queue head prediction metadata
// ---------------------------------------------------------------------------
package inst_fetch_pkg;

   typedef struct packed {
      logic stall_wb;
      logic stall_mem;
      logic stall_ex;
      logic stall_id;
      logic stall_if;
   } stall_t;

   typedef struct packed {
      logic adel_if;
      logic reserved_inst;
      logic syscall;
      logic brk;
      logic overflow;
      logic eret;
      logic adel_mem;
      logic ades_mem;
   } exceptType_t;

   // Metadata captured when a request is accepted.
   typedef struct packed {
      logic [31:0] pc;
      logic        bp_taken;
      logic [1:0]  bp_state;
      logic [31:0] bp_target;
   } fetch_tag_t;

   typedef struct packed {
      fetch_tag_t  tag;
      logic [31:0] inst;
      logic        adel;
   } fq_entry_t;

endpackage

module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  stall_t      stall,
   input  logic        flush,
   input  logic [31:0] flush_pc,
   input  logic        branch_flag,
   input  logic [31:0] branch_target,
   input  logic        bp_taken,
   input  logic [1:0]  bp_state,
   input  logic [31:0] bp_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_addr_ok,
   input  logic        imem_data_ok,
   input  logic [31:0] imem_rdata,
   output logic        pc_ce,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst,
   output logic        if_valid,
   output exceptType_t if_except,
   output logic        if_branch_predict,
   output logic [1:0]  if_branch_predict_state,
   output logic [31:0] if_branch_predict_target
);

   logic [31:0] pc_q, pc_d;
   logic        pc_ce_q, pc_ce_d;
   logic        halted_q, halted_d;
   logic        outstanding_q, outstanding_d;
   logic        cancel_q, cancel_d;
   logic        pend_q, pend_d;              // raised, waiting for addr_ok
   logic        pend_stale_q, pend_stale_d;  // held request predates a redirect
   logic [31:0] pend_addr_q, pend_addr_d;
   fetch_tag_t  tag_q, tag_d;
   fq_entry_t   fq_q [2];
   fq_entry_t   fq_d [2];
   logic [1:0]  cnt_q, cnt_d;

   logic        redirect, pop, slot_free, aligned, new_issue, req_int;
   logic        accept, resp, resp_push, misalign_push, push;
   logic [31:0] redirect_pc;
   logic [1:0]  base_cnt;
   fq_entry_t   new_entry;
   logic        unused_stall;

   assign unused_stall = ^{stall.stall_wb, stall.stall_mem, stall.stall_ex, stall.stall_id};

   assign redirect    = flush | branch_flag;
   assign redirect_pc = flush ? flush_pc : branch_target;
   assign pop         = (cnt_q != 2'd0) && !stall.stall_if;
   // The in-flight response is counted by refusing to issue unless a slot
   // will still be free after this cycle's pop.
   assign slot_free   = (cnt_q - 2'(pop)) != 2'd2;
   assign aligned     = (pc_q[1:0] == 2'b00);
   assign new_issue   = !halted_q && aligned && !outstanding_q && !pend_q && slot_free;
   assign req_int     = pend_q || new_issue;
   assign imem_addr   = pend_q ? pend_addr_q : pc_q;
   // Reset only masks the port; internal state is already held by the flops.
   assign imem_req    = rst_n && req_int;

   assign accept        = req_int && imem_addr_ok;
   assign resp          = imem_data_ok && outstanding_q;
   assign resp_push     = resp && !cancel_q && !redirect;
   assign misalign_push = !halted_q && !aligned && !outstanding_q && !pend_q
                          && slot_free && !redirect;
   assign push          = resp_push || misalign_push;

   always_comb begin
      // NOTE: every signal driven here gets its default first, so no path leaves a latch.
      pc_d          = pc_q;
      pc_ce_d       = 1'b1;
      halted_d      = halted_q;
      outstanding_d = outstanding_q;
      cancel_d      = cancel_q;
      tag_d         = tag_q;
      pend_d        = req_int && !imem_addr_ok;
      pend_addr_d   = imem_addr;
      pend_stale_d  = pend_d && (pend_stale_q || redirect);
      new_entry     = '0;
      fq_d          = fq_q;
      base_cnt      = cnt_q - 2'(pop);
      cnt_d         = base_cnt;

      if (resp) begin
         outstanding_d = 1'b0;
         cancel_d      = 1'b0;
      end

      if (accept) begin
         outstanding_d       = 1'b1;
         tag_d.pc            = imem_addr;
         tag_d.bp_taken      = bp_taken;
         tag_d.bp_state      = bp_state;
         tag_d.bp_target     = bp_target;
         // A held request from before a redirect is fetched but discarded.
         if (pend_stale_q) cancel_d = 1'b1;
      end

      if (redirect) begin
         pc_d     = redirect_pc;
         halted_d = 1'b0;
         if ((outstanding_q && !imem_data_ok) || accept) cancel_d = 1'b1;
      end else if (accept && !pend_stale_q) begin
         pc_d = bp_taken ? bp_target : pc_q + 32'd4;
      end

      if (misalign_push) halted_d = 1'b1;

      if (misalign_push) begin
         new_entry.tag.pc = pc_q;
         new_entry.adel   = 1'b1;
      end else begin
         new_entry.tag  = tag_q;
         new_entry.inst = imem_rdata;
      end

      if (pop) fq_d[0] = fq_q[1];
      if (push) begin
         fq_d[base_cnt[0]] = new_entry;
         cnt_d             = base_cnt + 2'd1;
      end
      if (redirect) cnt_d = 2'd0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q          <= RESET_PC;
         pc_ce_q       <= 1'b0;
         halted_q      <= 1'b0;
         outstanding_q <= 1'b0;
         cancel_q      <= 1'b0;
         pend_q        <= 1'b0;
         pend_stale_q  <= 1'b0;
         pend_addr_q   <= '0;
         tag_q         <= '0;
         cnt_q         <= 2'd0;
         // NOTE: the queue storage is reset because its head drives the if_* outputs directly.
         fq_q[0]       <= '0;
         fq_q[1]       <= '0;
      end else begin
         // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
         pc_q          <= pc_d;
         pc_ce_q       <= pc_ce_d;
         halted_q      <= halted_d;
         outstanding_q <= outstanding_d;
         cancel_q      <= cancel_d;
         pend_q        <= pend_d;
         pend_stale_q  <= pend_stale_d;
         pend_addr_q   <= pend_addr_d;
         tag_q         <= tag_d;
         cnt_q         <= cnt_d;
         fq_q[0]       <= fq_d[0];
         fq_q[1]       <= fq_d[1];
      end
   end

   assign pc_ce                    = pc_ce_q;
   assign if_valid                 = (cnt_q != 2'd0);
   assign if_pc                    = fq_q[0].tag.pc;
   assign if_inst                  = fq_q[0].inst;
   assign if_branch_predict        = fq_q[0].tag.bp_taken;
   assign if_branch_predict_state  = fq_q[0].tag.bp_state;
   assign if_branch_predict_target = fq_q[0].tag.bp_target;

   always_comb begin
      if_except         = '0;
      if_except.adel_if = fq_q[0].adel;
   end

endmodule

// File: tb/tb_inst_fetch.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch -- directed self-checking bench for inst_fetch.
// Memory model returns addr ^ 32'h1111_1111 with a configurable response
// delay; the bench records every instruction consumed by IF/ID.
// ---------------------------------------------------------------------------
module tb_inst_fetch;
   import inst_fetch_pkg::*;

   localparam logic [31:0] K      = 32'h1111_1111;
   localparam logic [31:0] BP_PC  = 32'h8000_0010;
   localparam logic [31:0] BP_TGT = 32'h8000_0100;

   logic        clk = 1'b0;
   logic        rst_n;
   stall_t      stall;
   logic        flush, branch_flag, bp_taken;
   logic [31:0] flush_pc, branch_target, bp_target;
   logic [1:0]  bp_state;
   logic        imem_req, imem_addr_ok, imem_data_ok;
   logic [31:0] imem_addr, imem_rdata;
   logic        pc_ce, if_valid, if_branch_predict;
   logic [31:0] if_pc, if_inst, if_branch_predict_target;
   logic [1:0]  if_branch_predict_state;
   exceptType_t if_except;

   always #5 clk = ~clk;

   inst_fetch dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .flush_pc(flush_pc),
      .branch_flag(branch_flag), .branch_target(branch_target),
      .bp_taken(bp_taken), .bp_state(bp_state), .bp_target(bp_target),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_addr_ok(imem_addr_ok),
      .imem_data_ok(imem_data_ok), .imem_rdata(imem_rdata), .pc_ce(pc_ce),
      .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid), .if_except(if_except),
      .if_branch_predict(if_branch_predict),
      .if_branch_predict_state(if_branch_predict_state),
      .if_branch_predict_target(if_branch_predict_target)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        bp;
      logic [1:0]  st;
      logic [31:0] tgt;
      exceptType_t exc;
   } rec_t;

   rec_t        got[$];
   int          checks = 0;
   int          failures = 0;
   bit          resp_pending;
   logic [31:0] resp_addr;
   int          resp_wait, data_lat, req_cycles;
   bit          bp_en;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive memory/predictor, record a consumed head, clock.
   task automatic tick();
      logic        req_s;
      logic [31:0] addr_s;
      rec_t        r;
      imem_data_ok = resp_pending && (resp_wait == 0);
      imem_rdata   = imem_data_ok ? (resp_addr ^ K) : 32'h0;
      #1;
      bp_taken     = bp_en && (imem_addr == BP_PC);
      bp_state     = bp_taken ? 2'b11 : 2'b00;
      bp_target    = bp_taken ? BP_TGT : 32'h0;
      imem_addr_ok = imem_req;
      #1;
      req_s  = imem_req;
      addr_s = imem_addr;
      if (req_s) req_cycles++;
      if (if_valid && !stall.stall_if && !flush && !branch_flag) begin
         r.pc  = if_pc;
         r.inst = if_inst;
         r.bp  = if_branch_predict;
         r.st  = if_branch_predict_state;
         r.tgt = if_branch_predict_target;
         r.exc = if_except;
         got.push_back(r);
      end
      @(posedge clk);
      if (imem_data_ok) resp_pending = 1'b0;
      else if (resp_pending && resp_wait > 0) resp_wait--;
      if (req_s && imem_addr_ok) begin
         resp_pending = 1'b1;
         resp_addr    = addr_s;
         resp_wait    = data_lat;
      end
      @(negedge clk);
   endtask

   task automatic run_until(input int n, input int budget, input string tag);
      int k;
      k = 0;
      while (got.size() < n && k < budget) begin
         tick();
         k++;
      end
      check({tag, "_timeout"}, 64'(got.size() >= n), 64'd1);
   endtask

   task automatic wait_pending(input string tag);
      int k;
      k = 0;
      while (!(resp_pending && resp_wait > 0) && k < 20) begin
         tick();
         k++;
      end
      check({tag, "_pending_timeout"}, 64'(resp_pending && resp_wait > 0), 64'd1);
   endtask

   task automatic check_rec(input string tag, input int idx, input logic [31:0] pc,
                            input logic [31:0] inst, input logic bp, input logic [1:0] st,
                            input logic [31:0] tgt, input logic adel);
      exceptType_t e;
      e = '0;
      e.adel_if = adel;
      check({tag, "_present"}, 64'(got.size() > idx), 64'd1);
      if (got.size() > idx) begin
         check({tag, "_pc"},   64'(got[idx].pc),   64'(pc));
         check({tag, "_inst"}, 64'(got[idx].inst), 64'(inst));
         check({tag, "_bp"},   64'(got[idx].bp),   64'(bp));
         check({tag, "_st"},   64'(got[idx].st),   64'(st));
         check({tag, "_tgt"},  64'(got[idx].tgt),  64'(tgt));
         check({tag, "_exc"},  64'(got[idx].exc),  64'(e));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] exp_head, a;
      rst_n = 1'b0; stall = '0; flush = 1'b0; flush_pc = '0;
      branch_flag = 1'b0; branch_target = '0;
      bp_taken = 1'b0; bp_state = '0; bp_target = '0;
      imem_addr_ok = 1'b0; imem_data_ok = 1'b0; imem_rdata = '0;
      resp_pending = 1'b0; resp_addr = '0; resp_wait = 0; data_lat = 0;
      req_cycles = 0; bp_en = 1'b0;

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_valid", 64'(if_valid), 64'd0);
      check("rst_req",   64'(imem_req), 64'd0);
      check("rst_pc_ce", 64'(pc_ce),    64'd0);
      check("rst_if_pc", 64'(if_pc),    64'd0);
      check("rst_inst",  64'(if_inst),  64'd0);

      // Startup timing with zero-wait memory
      rst_n = 1'b1;
      #1;
      check("c0_req",   64'(imem_req),  64'd1);
      check("c0_addr",  64'(imem_addr), 64'(32'hBFC0_0000));
      check("c0_pc_ce", 64'(pc_ce),     64'd0);
      tick();
      check("c1_pc_ce", 64'(pc_ce),    64'd1);
      check("c1_valid", 64'(if_valid), 64'd0);
      tick();
      check("c2_valid", 64'(if_valid), 64'd1);
      check("c2_pc",    64'(if_pc),    64'(32'hBFC0_0000));
      check("c2_inst",  64'(if_inst),  64'(32'hAED1_1111));
      run_until(3, 40, "stream");

      // Stall for 6 cycles: head holds, queue fills, requests stop
      exp_head = 32'hBFC0_0000 + 32'(4 * got.size());
      stall.stall_if = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) begin
         tick();
         check("stall_pc",   64'(if_pc),   64'(exp_head));
         check("stall_inst", 64'(if_inst), 64'(exp_head ^ K));
      end
      check("stall_full_req", 64'(imem_req), 64'd0);
      check("stall_valid",    64'(if_valid), 64'd1);
      stall.stall_if = 1'b0;
      run_until(8, 80, "post_stall");
      for (int i = 0; i < 8; i++) begin
         a = 32'hBFC0_0000 + 32'(4 * i);
         check_rec("seq", i, a, a ^ K, 1'b0, 2'b00, 32'h0, 1'b0);
      end

      // Predicted-taken branch at 8000_0010
      bp_en = 1'b1;
      branch_flag = 1'b1; branch_target = BP_PC;
      tick();
      branch_flag = 1'b0;
      got.delete();
      check("bp_redir_empty", 64'(if_valid), 64'd0);
      run_until(2, 40, "bp");
      check_rec("bp0", 0, BP_PC,  BP_PC ^ K,  1'b1, 2'b11, BP_TGT, 1'b0);
      check_rec("bp1", 1, BP_TGT, BP_TGT ^ K, 1'b0, 2'b00, 32'h0,  1'b0);
      bp_en = 1'b0;

      // Mispredict while a slow response is outstanding
      data_lat = 3;
      wait_pending("late");
      branch_flag = 1'b1; branch_target = 32'h8000_0200;
      tick();
      branch_flag = 1'b0;
      got.delete();
      check("late_redir_empty", 64'(if_valid), 64'd0);
      run_until(1, 60, "late");
      check_rec("late0", 0, 32'h8000_0200, 32'h8000_0200 ^ K, 1'b0, 2'b00, 32'h0, 1'b0);
      data_lat = 0;

      // flush wins over branch_flag
      flush = 1'b1; flush_pc = 32'h8000_0380;
      branch_flag = 1'b1; branch_target = 32'h8000_0500;
      tick();
      flush = 1'b0; branch_flag = 1'b0;
      got.delete();
      check("flush_empty", 64'(if_valid), 64'd0);
      run_until(1, 40, "flush");
      check_rec("flush0", 0, 32'h8000_0380, 32'h8000_0380 ^ K, 1'b0, 2'b00, 32'h0, 1'b0);

      // Misaligned target: one address-error entry, then halt
      branch_flag = 1'b1; branch_target = 32'h8000_0002;
      tick();
      branch_flag = 1'b0;
      got.delete();
      req_cycles = 0;
      repeat (12) tick();
      check("mis_noreq", 64'(req_cycles), 64'd0);
      check("mis_count", 64'(got.size()), 64'd1);
      check_rec("mis0", 0, 32'h8000_0002, 32'h0, 1'b0, 2'b00, 32'h0, 1'b1);
      check("mis_halt_valid", 64'(if_valid), 64'd0);

      // flush resumes fetching
      flush = 1'b1; flush_pc = 32'hBFC0_0380;
      tick();
      flush = 1'b0;
      run_until(2, 40, "resume");
      check_rec("resume", 1, 32'hBFC0_0380, 32'hBFC0_0380 ^ K, 1'b0, 2'b00, 32'h0, 1'b0);

      // Reset asserted with a response outstanding
      data_lat = 3;
      wait_pending("mid_rst");
      rst_n = 1'b0;
      #1;
      check("mrst_valid", 64'(if_valid), 64'd0);
      check("mrst_req",   64'(imem_req), 64'd0);
      check("mrst_pc_ce", 64'(pc_ce),    64'd0);
      check("mrst_if_pc", 64'(if_pc),    64'd0);
      got.delete();
      repeat (5) tick();
      data_lat = 0;
      rst_n = 1'b1;
      #1;
      check("mrst_c0_addr", 64'(imem_addr), 64'(32'hBFC0_0000));
      run_until(2, 40, "mrst");
      check_rec("mrst0", 0, 32'hBFC0_0000, 32'hBFC0_0000 ^ K, 1'b0, 2'b00, 32'h0, 1'b0);
      check_rec("mrst1", 1, 32'hBFC0_0004, 32'hBFC0_0004 ^ K, 1'b0, 2'b00, 32'h0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
